// File: rtl/param_shift_register_if.sv
// Bus bundle for param_shift_register: op controls, burst handshake and data paths.
// The master drives the request side; the slave (the shift register) returns data and status.
interface param_shift_register_if #(
    parameter int WIDTH = 16,
    parameter int STEP  = 1,
    parameter int CNT_W = 5
);
    logic             en;
    logic [2:0]       mode;
    logic             start;
    logic [CNT_W-1:0] count;
    logic [STEP-1:0]  ser_in;
    logic [WIDTH-1:0] data_in;
    logic [WIDTH-1:0] data_out;
    logic [STEP-1:0]  ser_out;
    logic             busy;
    logic             done;

    modport master (
        output en, mode, start, count, ser_in, data_in,
        input  data_out, ser_out, busy, done
    );

    modport slave (
        input  en, mode, start, count, ser_in, data_in,
        output data_out, ser_out, busy, done
    );
endinterface

// File: rtl/param_shift_register.sv
// Universal shift register with single-step ops on en and FSM-driven multi-step bursts.
// The burst FSM latches its mode at start so the mode input is free while busy.
module param_shift_register #(
    parameter int WIDTH = 16,
    parameter int STEP  = 1,
    parameter int CNT_W = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    param_shift_register_if.slave bus
);

    typedef enum logic [2:0] {
        M_HOLD = 3'd0,
        M_LOAD = 3'd1,
        M_SHL  = 3'd2,
        M_SHR  = 3'd3,
        M_ROL  = 3'd4,
        M_ROR  = 3'd5,
        M_ASR  = 3'd6,
        M_CLR  = 3'd7
    } mode_e;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_e;

    state_e           state_q, state_d;
    mode_e            lmode_q, lmode_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             done_q, done_d;

    mode_e            act_mode;
    mode_e            in_mode;
    logic [WIDTH-1:0] op_result;
    logic             is_shift_mode;

    assign in_mode  = mode_e'(bus.mode);
    assign act_mode = (state_q == S_RUN) ? lmode_q : in_mode;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        op_result = data_q;
        case (act_mode)
            M_LOAD:  op_result = bus.data_in;
            M_SHL:   op_result = {data_q[WIDTH-1-STEP:0], bus.ser_in};
            M_SHR:   op_result = {bus.ser_in, data_q[WIDTH-1:STEP]};
            M_ROL:   op_result = {data_q[WIDTH-1-STEP:0], data_q[WIDTH-1 -: STEP]};
            M_ROR:   op_result = {data_q[STEP-1:0], data_q[WIDTH-1:STEP]};
            M_ASR:   op_result = {{STEP{data_q[WIDTH-1]}}, data_q[WIDTH-1:STEP]};
            M_CLR:   op_result = '0;
            default: op_result = data_q;
        endcase
    end

    always_comb begin
        bus.ser_out = '0;
        case (act_mode)
            M_SHL, M_ROL:        bus.ser_out = data_q[WIDTH-1 -: STEP];
            M_SHR, M_ROR, M_ASR: bus.ser_out = data_q[STEP-1:0];
            default:             bus.ser_out = '0;
        endcase
    end

    assign is_shift_mode = (in_mode == M_SHL) || (in_mode == M_SHR) || (in_mode == M_ROL) ||
                           (in_mode == M_ROR) || (in_mode == M_ASR);

    // Burst activity outranks start, which outranks a plain single op.
    always_comb begin
        state_d = state_q;
        lmode_d = lmode_q;
        rem_d   = rem_q;
        data_d  = data_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    if (bus.count == '0) begin
                        done_d = 1'b1;
                    end else if (is_shift_mode) begin
                        lmode_d = in_mode;
                        rem_d   = bus.count;
                        state_d = S_RUN;
                    end else begin
                        data_d = op_result;
                        done_d = 1'b1;
                    end
                end else if (bus.en) begin
                    data_d = op_result;
                end
            end
            S_RUN: begin
                if (bus.en) begin
                    data_d = op_result;
                    rem_d  = rem_q - CNT_W'(1);
                    if (rem_q == CNT_W'(1)) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            lmode_q <= M_HOLD;
            rem_q   <= '0;
            data_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            lmode_q <= lmode_d;
            rem_q   <= rem_d;
            data_q  <= data_d;
            done_q  <= done_d;
        end
    end

    assign bus.data_out = data_q;
    assign bus.busy     = (state_q == S_RUN);
    assign bus.done     = done_q;

endmodule

// File: tb/tb_param_shift_register.sv
// Bench for param_shift_register: directed scenarios with literal results, then random
// traffic compared every cycle against a behavioural model built from vector arithmetic.
module tb_param_shift_register;

    localparam int W  = 16;
    localparam int S  = 1;
    localparam int CW = 5;

    logic clk;
    logic rst_n;
    bit   cmp_en;
    int   n_cmp;
    int   n_bad;

    param_shift_register_if #(.WIDTH(W), .STEP(S), .CNT_W(CW)) bus1 ();
    param_shift_register_if #(.WIDTH(16), .STEP(4), .CNT_W(5))  bus4 ();

    param_shift_register #(.WIDTH(W), .STEP(S), .CNT_W(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1.slave)
    );

    param_shift_register #(.WIDTH(16), .STEP(4), .CNT_W(5)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus4.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: the register as a plain vector, bursts as a count of pending steps.
    logic [W-1:0] m_data;
    int           m_left;
    logic [2:0]   m_bmode;
    bit           m_done;

    function automatic logic [W-1:0] model_op(input logic [2:0] m, input logic [W-1:0] d,
                                              input logic [S-1:0] si, input logic [W-1:0] din);
        logic [W-1:0] ext;
        ext = W'(si);
        case (m)
            3'd1:    return din;
            3'd2:    return (d << S) | ext;
            3'd3:    return (d >> S) | (ext << (W - S));
            3'd4:    return (d << S) | (d >> (W - S));
            3'd5:    return (d >> S) | (d << (W - S));
            3'd6:    return $unsigned($signed(d) >>> S);
            3'd7:    return '0;
            default: return d;
        endcase
    endfunction

    function automatic logic [S-1:0] model_ser(input logic [2:0] m, input logic [W-1:0] d);
        logic [W-1:0] t;
        t = '0;
        if (m == 3'd2 || m == 3'd4) t = d >> (W - S);
        else if (m == 3'd3 || m == 3'd5 || m == 3'd6) t = d;
        return t[S-1:0];
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_data  = '0;
            m_left  = 0;
            m_bmode = 3'd0;
            m_done  = 1'b0;
        end else begin
            bit nd;
            nd = 1'b0;
            if (m_left > 0) begin
                if (bus1.en) begin
                    m_data = model_op(m_bmode, m_data, bus1.ser_in, bus1.data_in);
                    m_left = m_left - 1;
                    if (m_left == 0) nd = 1'b1;
                end
            end else if (bus1.start) begin
                if (bus1.count == 0) begin
                    nd = 1'b1;
                end else if (bus1.mode >= 3'd2 && bus1.mode <= 3'd6) begin
                    m_bmode = bus1.mode;
                    m_left  = int'(bus1.count);
                end else begin
                    m_data = model_op(bus1.mode, m_data, bus1.ser_in, bus1.data_in);
                    nd     = 1'b1;
                end
            end else if (bus1.en) begin
                m_data = model_op(bus1.mode, m_data, bus1.ser_in, bus1.data_in);
            end
            m_done = nd;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("data_out", 32'(bus1.data_out), 32'(m_data));
            check("ser_out", 32'(bus1.ser_out),
                  32'(model_ser((m_left > 0) ? m_bmode : bus1.mode, m_data)));
            check("busy", 32'(bus1.busy), 32'(m_left > 0));
            check("done", 32'(bus1.done), 32'(m_done));
            check("busy_done_excl", 32'(bus1.busy & bus1.done), 32'd0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle1();
        bus1.en = 1'b0; bus1.start = 1'b0; bus1.mode = 3'd0;
        bus1.count = '0; bus1.ser_in = '0; bus1.data_in = '0;
    endtask

    task automatic load1(input logic [W-1:0] v);
        bus1.en = 1'b1; bus1.mode = 3'd1; bus1.data_in = v;
        tick();
        bus1.en = 1'b0;
    endtask

    task automatic start1(input logic [2:0] m, input int c);
        bus1.start = 1'b1; bus1.en = 1'b1; bus1.mode = m; bus1.count = CW'(c);
        tick();
        bus1.start = 1'b0;
    endtask

    // Ticks until done rises (bounded); returns busy cycles observed and whether done came.
    task automatic wait_done(input int busy_in, output int busy_n, output bit seen);
        busy_n = busy_in;
        seen   = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (bus1.done) begin
                seen = 1'b1;
                break;
            end
            if (bus1.busy) busy_n++;
        end
    endtask

    initial begin
        int  bn;
        bit  seen;
        n_cmp = 0; n_bad = 0; cmp_en = 1'b0;
        idle1();
        bus4.en = 1'b0; bus4.start = 1'b0; bus4.mode = 3'd0;
        bus4.count = '0; bus4.ser_in = '0; bus4.data_in = '0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        tick(); tick();
        check("reset_data", 32'(bus1.data_out), 32'h0);
        check("reset_busy", 32'(bus1.busy), 32'h0);
        check("reset_done", 32'(bus1.done), 32'h0);
        rst_n = 1'b1;
        cmp_en = 1'b1;

        // Single SHR with fill bit
        load1(16'hA5C3);
        check("t1_load", 32'(bus1.data_out), 32'hA5C3);
        bus1.en = 1'b1; bus1.mode = 3'd3; bus1.ser_in = 1'b1;
        #1 check("t1_ser_out", 32'(bus1.ser_out), 32'h1);
        tick();
        bus1.en = 1'b0;
        check("t1_shr", 32'(bus1.data_out), 32'hD2E1);

        // ASR keeps the sign, then CLR
        load1(16'h8001);
        bus1.en = 1'b1; bus1.mode = 3'd6; tick();
        check("t2_asr", 32'(bus1.data_out), 32'hC000);
        bus1.mode = 3'd7; tick();
        bus1.en = 1'b0;
        check("t2_clr", 32'(bus1.data_out), 32'h0);

        // ROL burst of 4
        load1(16'h1234);
        start1(3'd4, 4);
        check("t3_busy_start", 32'(bus1.busy), 32'h1);
        check("t3_data_start", 32'(bus1.data_out), 32'h1234);
        wait_done(1, bn, seen);
        check("t3_done_seen", 32'(seen), 32'h1);
        check("t3_busy_cycles", 32'(bn), 32'd4);
        check("t3_result", 32'(bus1.data_out), 32'h2341);
        tick();
        check("t3_done_pulse", 32'(bus1.done), 32'h0);
        bus1.en = 1'b0;

        // Same burst with a two-cycle stall and a start request while busy
        load1(16'h1234);
        start1(3'd4, 4);
        tick();
        bus1.en = 1'b0; bus1.start = 1'b1; bus1.mode = 3'd2; bus1.count = CW'(9);
        tick(); tick();
        check("t4_stall_busy", 32'(bus1.busy), 32'h1);
        bus1.en = 1'b1; bus1.start = 1'b0; bus1.mode = 3'd4;
        wait_done(4, bn, seen);
        check("t4_done_seen", 32'(seen), 32'h1);
        check("t4_busy_cycles", 32'(bn), 32'd6);
        check("t4_result", 32'(bus1.data_out), 32'h2341);
        bus1.en = 1'b0;
        tick();
        check("t4_no_second", 32'(bus1.busy | bus1.done), 32'h0);

        // Async reset mid-burst, then a fresh burst
        load1(16'h00FF);
        start1(3'd5, 8);
        tick(); tick();
        rst_n = 1'b0;
        #1;
        check("t5_rst_data", 32'(bus1.data_out), 32'h0);
        check("t5_rst_busy", 32'(bus1.busy), 32'h0);
        tick();
        rst_n = 1'b1;
        load1(16'h0001);
        bus1.ser_in = 1'b0;
        start1(3'd2, 2);
        check("t5_restart_busy", 32'(bus1.busy), 32'h1);
        wait_done(1, bn, seen);
        check("t5_done_seen", 32'(seen), 32'h1);
        check("t5_result", 32'(bus1.data_out), 32'h0004);
        idle1();

        // STEP=4 instance: nibble shift and zero-count start
        bus4.en = 1'b1; bus4.mode = 3'd1; bus4.data_in = 16'h1234;
        tick();
        check("t6_load", 32'(bus4.data_out), 32'h1234);
        bus4.mode = 3'd2; bus4.ser_in = 4'hF;
        tick();
        check("t6_shl4", 32'(bus4.data_out), 32'h234F);
        bus4.en = 1'b0; bus4.start = 1'b1; bus4.mode = 3'd4; bus4.count = '0;
        tick();
        bus4.start = 1'b0;
        check("t6_cnt0_data", 32'(bus4.data_out), 32'h234F);
        check("t6_cnt0_done", 32'(bus4.done), 32'h1);
        check("t6_cnt0_busy", 32'(bus4.busy), 32'h0);
        tick();
        check("t6_done_pulse", 32'(bus4.done), 32'h0);

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 499) == 0) begin
                rst_n = 1'b0;
                tick();
                rst_n = 1'b1;
            end
            bus1.en      = ($urandom_range(0, 3) != 0);
            bus1.start   = ($urandom_range(0, 7) == 0);
            bus1.mode    = 3'($urandom_range(0, 7));
            bus1.count   = ($urandom_range(0, 9) == 0) ? CW'($urandom) : CW'($urandom_range(0, 6));
            bus1.ser_in  = S'($urandom);
            bus1.data_in = W'($urandom);
            tick();
        end
        idle1();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
